mem_stage: RTL and testbench

Memory-access pipeline stage: the consumer of the execute-stage output bundle. It turns execute results carrying a load/store op into a data-bus transaction with byte strobes and alignment checks. It returns load data sign- or zero-extended, and hands a registered result bundle to writeback. Non-memory results pass through with one cycle of latency. Loads and stores block the stage until the bus responds.

---
 rtl/mem_stage.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: execute bundle in, data-bus access,
// extended load data and a registered bundle out to writeback.
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int LSU_OP_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_pc,
    input  logic [DATA_WIDTH-1:0]     ex_inst,
    input  logic [DATA_WIDTH-1:0]     ex_result,
    input  logic [LSU_OP_WIDTH-1:0]   ex_lsu_op,
    input  logic [DATA_WIDTH-1:0]     ex_lsu_data,
    input  logic                      ex_rw_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rw_addr,

    output logic                      dreq_valid,
    input  logic                      dreq_ready,
    output logic                      dreq_we,
    output logic [DATA_WIDTH-1:0]     dreq_addr,
    output logic [3:0]                dreq_wstrb,
    output logic [DATA_WIDTH-1:0]     dreq_wdata,
    input  logic                      drsp_valid,
    input  logic [DATA_WIDTH-1:0]     drsp_rdata,

    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_pc,
    output logic [DATA_WIDTH-1:0]     mem_inst,
    output logic                      mem_rw_en,
    output logic [REG_ADDR_WIDTH-1:0] mem_rw_addr,
    output logic [DATA_WIDTH-1:0]     mem_rw_data,
    output logic                      mem_ale
);

    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_B  = LSU_OP_WIDTH'(1);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_H  = LSU_OP_WIDTH'(2);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_W  = LSU_OP_WIDTH'(3);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_BU = LSU_OP_WIDTH'(4);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_HU = LSU_OP_WIDTH'(5);
    localparam logic [LSU_OP_WIDTH-1:0] OP_ST_B  = LSU_OP_WIDTH'(6);
    localparam logic [LSU_OP_WIDTH-1:0] OP_ST_H  = LSU_OP_WIDTH'(7);
    localparam logic [LSU_OP_WIDTH-1:0] OP_ST_W  = LSU_OP_WIDTH'(8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    typedef struct packed {
        logic  ld;
        logic  st;
        logic  sext;
        size_t size;
    } op_info_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     inst;
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     data;
        logic [LSU_OP_WIDTH-1:0]   op;
        logic                      rw_en;
        logic [REG_ADDR_WIDTH-1:0] rw_addr;
    } ex_bundle_t;

    function automatic op_info_t decode_op(
        input logic [LSU_OP_WIDTH-1:0] op
    );
        op_info_t info;
        info = '{ld: 1'b0, st: 1'b0, sext: 1'b0, size: SZ_W};
        case (op)
            OP_LD_B:  info = '{ld: 1'b1, st: 1'b0, sext: 1'b1, size: SZ_B};
            OP_LD_H:  info = '{ld: 1'b1, st: 1'b0, sext: 1'b1, size: SZ_H};
            OP_LD_W:  info = '{ld: 1'b1, st: 1'b0, sext: 1'b0, size: SZ_W};
            OP_LD_BU: info = '{ld: 1'b1, st: 1'b0, sext: 1'b0, size: SZ_B};
            OP_LD_HU: info = '{ld: 1'b1, st: 1'b0, sext: 1'b0, size: SZ_H};
            OP_ST_B:  info = '{ld: 1'b0, st: 1'b1, sext: 1'b0, size: SZ_B};
            OP_ST_H:  info = '{ld: 1'b0, st: 1'b1, sext: 1'b0, size: SZ_H};
            OP_ST_W:  info = '{ld: 1'b0, st: 1'b1, sext: 1'b0, size: SZ_W};
            default:  info = '{ld: 1'b0, st: 1'b0, sext: 1'b0, size: SZ_W};
        endcase
        return info;
    endfunction

    function automatic logic is_mem_op(
        input logic [LSU_OP_WIDTH-1:0] op
    );
        op_info_t info;
        info = decode_op(op);
        return info.ld | info.st;
    endfunction

    function automatic logic is_misaligned(
        input logic [LSU_OP_WIDTH-1:0] op,
        input logic [1:0]              a
    );
        op_info_t info;
        logic     mis;
        info = decode_op(op);
        mis  = 1'b0;
        if (info.ld || info.st) begin
            unique case (1'b1)
                info.size == SZ_H: mis = a[0];
                info.size == SZ_W: mis = |a;
                default:           mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

    state_t     state_q;
    state_t     state_d;
    ex_bundle_t req_q;
    op_info_t   req_info;

    logic       accept;
    logic       out_free;
    logic       in_mem;
    logic       in_mis;
    logic       direct_load;
    logic       resp_load;
    logic [1:0] req_off;

    logic [15:0]           lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Handshake and classification of the incoming bundle
    always_comb begin
        out_free    = !mem_valid || mem_ready;
        ex_ready    = (state_q == IDLE) && out_free;
        accept      = ex_valid && ex_ready;
        in_mem      = is_mem_op(ex_lsu_op);
        in_mis      = is_misaligned(ex_lsu_op, ex_result[1:0]);
        direct_load = accept && (!in_mem || in_mis);
        resp_load   = (state_q == RESP) && drsp_valid;
        req_info    = decode_op(req_q.op);
        req_off     = req_q.result[1:0];
    end

    // FSM state register; reset aborts any bus transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && in_mem && !in_mis) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dreq_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (drsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the accepted bundle for the duration of the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.pc      <= ex_pc;
            req_q.inst    <= ex_inst;
            req_q.result  <= ex_result;
            req_q.data    <= ex_lsu_data;
            req_q.op      <= ex_lsu_op;
            req_q.rw_en   <= ex_rw_en;
            req_q.rw_addr <= ex_rw_addr;
        end
    end

    // Bus request: driven from the captured bundle, stable through REQ
    always_comb begin
        dreq_valid = 1'b0;
        dreq_we    = 1'b0;
        dreq_addr  = '0;
        dreq_wstrb = 4'b0000;
        dreq_wdata = '0;
        if (state_q == REQ) begin
            dreq_valid = 1'b1;
            dreq_we    = req_info.st;
            dreq_addr  = {req_q.result[DATA_WIDTH-1:2], 2'b00};
            if (req_info.st) begin
                unique case (1'b1)
                    req_info.size == SZ_B: begin
                        dreq_wstrb = 4'b0001 << req_off;
                        dreq_wdata = {(DATA_WIDTH/8){req_q.data[7:0]}};
                    end
                    req_info.size == SZ_H: begin
                        dreq_wstrb = 4'b0011 << req_off;
                        dreq_wdata = {(DATA_WIDTH/16){req_q.data[15:0]}};
                    end
                    default: begin
                        dreq_wstrb = 4'b1111;
                        dreq_wdata = req_q.data;
                    end
                endcase
            end
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        lane      = 16'(drsp_rdata >> {req_off, 3'b000});
        load_data = drsp_rdata;
        unique case (1'b1)
            req_info.size == SZ_B: begin
                load_data = {{(DATA_WIDTH-8){req_info.sext & lane[7]}},
                             lane[7:0]};
            end
            req_info.size == SZ_H: begin
                load_data = {{(DATA_WIDTH-16){req_info.sext & lane[15]}},
                             lane[15:0]};
            end
            default: load_data = drsp_rdata;
        endcase
        rsp_data = req_info.ld ? load_data : req_q.result;
    end

    // Writeback output register: hold on stall, replace or drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid   <= 1'b0;
            mem_pc      <= '0;
            mem_inst    <= '0;
            mem_rw_en   <= 1'b0;
            mem_rw_addr <= '0;
            mem_rw_data <= '0;
            mem_ale     <= 1'b0;
        end else if (direct_load) begin
            mem_valid   <= 1'b1;
            mem_pc      <= ex_pc;
            mem_inst    <= ex_inst;
            mem_rw_en   <= ex_rw_en & ~in_mis;
            mem_rw_addr <= ex_rw_addr;
            mem_rw_data <= ex_result;
            mem_ale     <= in_mis;
        end else if (resp_load) begin
            mem_valid   <= 1'b1;
            mem_pc      <= req_q.pc;
            mem_inst    <= req_q.inst;
            mem_rw_en   <= req_q.rw_en;
            mem_rw_addr <= req_q.rw_addr;
            mem_rw_data <= rsp_data;
            mem_ale     <= 1'b0;
        end else if (mem_ready) begin
            mem_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed plan steps plus randomized bundles
// checked against an arithmetic model of the load/store rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_result;
    logic [3:0]  ex_lsu_op;
    logic [31:0] ex_lsu_data;
    logic        ex_rw_en;
    logic [4:0]  ex_rw_addr;
    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_we;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_wstrb;
    logic [31:0] dreq_wdata;
    logic        drsp_valid;
    logic [31:0] drsp_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic        mem_rw_en;
    logic [4:0]  mem_rw_addr;
    logic [31:0] mem_rw_data;
    logic        mem_ale;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_pc       (ex_pc),
        .ex_inst     (ex_inst),
        .ex_result   (ex_result),
        .ex_lsu_op   (ex_lsu_op),
        .ex_lsu_data (ex_lsu_data),
        .ex_rw_en    (ex_rw_en),
        .ex_rw_addr  (ex_rw_addr),
        .dreq_valid  (dreq_valid),
        .dreq_ready  (dreq_ready),
        .dreq_we     (dreq_we),
        .dreq_addr   (dreq_addr),
        .dreq_wstrb  (dreq_wstrb),
        .dreq_wdata  (dreq_wdata),
        .drsp_valid  (drsp_valid),
        .drsp_rdata  (drsp_rdata),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_pc      (mem_pc),
        .mem_inst    (mem_inst),
        .mem_rw_en   (mem_rw_en),
        .mem_rw_addr (mem_rw_addr),
        .mem_rw_data (mem_rw_data),
        .mem_ale     (mem_ale)
    );

    typedef struct {
        logic        mem;
        logic        ale;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rw_data;
        logic        rw_en;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int op, input logic [31:0] addr,
                                   input logic [31:0] sdata,
                                   input logic [31:0] rdata,
                                   input logic rwe);
        exp_t   e;
        bit     ld;
        bit     st;
        int     nb;
        int     off;
        longint v;
        ld  = (op >= 1) && (op <= 5);
        st  = (op >= 6) && (op <= 8);
        nb  = (op == 1 || op == 4 || op == 6) ? 1 :
              (op == 2 || op == 5 || op == 7) ? 2 : 4;
        off = int'(addr % 4);
        e.mem   = (ld || st) && (addr % nb == 0);
        e.ale   = (ld || st) && (addr % nb != 0);
        e.we    = st;
        e.strb  = st ? 4'(((1 << nb) - 1) << off) : 4'd0;
        e.wdata = (nb == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                  (nb == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
        v = longint'((64'(rdata) >> (8 * off)) & ((64'd1 << (8 * nb)) - 1));
        if ((op == 1 || op == 2) && v >= longint'(64'd1 << (8 * nb - 1)))
            v = v - longint'(64'd1 << (8 * nb));
        e.rw_data = (ld && e.mem) ? 32'(v) : addr;
        e.rw_en   = rwe && !e.ale;
        return e;
    endfunction

    task automatic run_txn(input string tag, input int op,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input logic [31:0] pc,
                           input logic rwe, input logic [4:0] rwa,
                           input int rdly, input int sdly, input int stall);
        exp_t e;
        e = model(op, addr, sdata, rdata, rwe);
        ex_valid    = 1'b1;
        ex_pc       = pc;
        ex_inst     = ~pc;
        ex_result   = addr;
        ex_lsu_op   = 4'(op);
        ex_lsu_data = sdata;
        ex_rw_en    = rwe;
        ex_rw_addr  = rwa;
        mem_ready   = 1'b1;
        dreq_ready  = 1'b0;
        drsp_valid  = 1'b0;
        #1;
        check({tag, ".ex_ready"}, 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        ex_valid  = 1'b0;
        ex_lsu_op = 4'd0;
        mem_ready = (stall == 0);
        if (e.mem) begin
            check({tag, ".dreq_valid"}, 32'(dreq_valid), 32'd1);
            check({tag, ".dreq_we"}, 32'(dreq_we), 32'(e.we));
            check({tag, ".dreq_addr"}, dreq_addr, {addr[31:2], 2'b00});
            check({tag, ".dreq_wstrb"}, 32'(dreq_wstrb), 32'(e.strb));
            if (e.we) check({tag, ".dreq_wdata"}, dreq_wdata, e.wdata);
            check({tag, ".busy_ex_ready"}, 32'(ex_ready), 32'd0);
            for (int i = 0; i < rdly; i++) begin
                drsp_valid = (i == 0);
                drsp_rdata = $urandom;
                @(posedge clk); #1;
                check({tag, ".req_hold"}, 32'(dreq_valid), 32'd1);
                check({tag, ".req_addr"}, dreq_addr, {addr[31:2], 2'b00});
                check({tag, ".req_strb"}, 32'(dreq_wstrb), 32'(e.strb));
                check({tag, ".req_ex_ready"}, 32'(ex_ready), 32'd0);
            end
            drsp_valid = 1'b0;
            dreq_ready = 1'b1;
            @(posedge clk); #1;
            dreq_ready = 1'b0;
            check({tag, ".resp_dreq"}, 32'(dreq_valid), 32'd0);
            check({tag, ".resp_mv"}, 32'(mem_valid), 32'd0);
            for (int i = 0; i < sdly; i++) begin
                @(posedge clk); #1;
                check({tag, ".wait_mv"}, 32'(mem_valid), 32'd0);
                check({tag, ".wait_ex_ready"}, 32'(ex_ready), 32'd0);
            end
            drsp_valid = 1'b1;
            drsp_rdata = rdata;
            @(posedge clk); #1;
            drsp_valid = 1'b0;
            drsp_rdata = $urandom;
        end else begin
            check({tag, ".no_dreq"}, 32'(dreq_valid), 32'd0);
        end
        check({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
        check({tag, ".rw_data"}, mem_rw_data, e.rw_data);
        check({tag, ".rw_en"}, 32'(mem_rw_en), 32'(e.rw_en));
        check({tag, ".rw_addr"}, 32'(mem_rw_addr), 32'(rwa));
        check({tag, ".ale"}, 32'(mem_ale), 32'(e.ale));
        check({tag, ".pc"}, mem_pc, pc);
        check({tag, ".inst"}, mem_inst, ~pc);
        for (int i = 0; i < stall; i++) begin
            ex_valid  = 1'b1;
            ex_lsu_op = 4'd0;
            ex_result = ~e.rw_data;
            #1;
            check({tag, ".stall_ex_ready"}, 32'(ex_ready), 32'd0);
            @(posedge clk); #1;
            check({tag, ".stall_mv"}, 32'(mem_valid), 32'd1);
            check({tag, ".stall_data"}, mem_rw_data, e.rw_data);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        int          op;
        logic [31:0] addr;
        int          r;

        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_pc       = '0;
        ex_inst     = '0;
        ex_result   = '0;
        ex_lsu_op   = '0;
        ex_lsu_data = '0;
        ex_rw_en    = 1'b0;
        ex_rw_addr  = '0;
        dreq_ready  = 1'b0;
        drsp_valid  = 1'b0;
        drsp_rdata  = '0;
        mem_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst.mem_valid", 32'(mem_valid), 32'd0);
        check("rst.dreq_valid", 32'(dreq_valid), 32'd0);
        check("rst.dreq_we", 32'(dreq_we), 32'd0);
        check("rst.dreq_wstrb", 32'(dreq_wstrb), 32'd0);
        check("rst.dreq_addr", dreq_addr, 32'd0);
        check("rst.mem_ale", 32'(mem_ale), 32'd0);
        check("rst.mem_rw_en", 32'(mem_rw_en), 32'd0);
        check("rst.mem_rw_data", mem_rw_data, 32'd0);
        check("rst.mem_pc", mem_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.ex_ready", 32'(ex_ready), 32'd1);

        run_txn("pass", 0, 32'h1234_5678, 32'h0, 32'h0, 32'h100,
                1'b1, 5'd5, 0, 0, 0);
        check("pass.const", mem_rw_data, 32'h1234_5678);
        run_txn("ldb", 1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 32'h104,
                1'b1, 5'd6, 0, 0, 0);
        check("ldb.const", mem_rw_data, 32'hFFFF_FF80);
        run_txn("ldbu", 4, 32'h0000_1003, 32'h0, 32'h80FF_0000, 32'h108,
                1'b1, 5'd7, 0, 0, 0);
        check("ldbu.const", mem_rw_data, 32'h0000_0080);
        run_txn("sth", 7, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 32'h10C,
                1'b0, 5'd0, 0, 0, 0);
        run_txn("ldw_mis", 3, 32'h0000_3001, 32'h0, 32'h0, 32'h110,
                1'b1, 5'd9, 0, 0, 0);
        run_txn("bp", 3, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 32'h114,
                1'b1, 5'd10, 3, 1, 2);
        run_txn("bp_next", 0, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h118,
                1'b1, 5'd11, 0, 0, 0);
        run_txn("ldh", 2, 32'h0000_6002, 32'h0, 32'h9ABC_1234, 32'h11C,
                1'b1, 5'd12, 1, 0, 0);
        run_txn("ldhu", 5, 32'h0000_6002, 32'h0, 32'h9ABC_1234, 32'h120,
                1'b1, 5'd13, 0, 2, 0);
        run_txn("stb", 6, 32'h0000_7001, 32'h1234_56A5, 32'h0, 32'h124,
                1'b1, 5'd14, 0, 0, 1);
        run_txn("stw", 8, 32'h0000_7008, 32'hDEAD_BEEF, 32'h0, 32'h128,
                1'b1, 5'd15, 2, 0, 0);
        run_txn("op12", 12, 32'h0000_7003, 32'h0, 32'h0, 32'h12C,
                1'b1, 5'd16, 0, 0, 0);
        run_txn("sth_mis", 7, 32'h0000_7005, 32'h1111, 32'h0, 32'h130,
                1'b1, 5'd17, 0, 0, 0);
        run_txn("stw_mis", 8, 32'h0000_7006, 32'h2222, 32'h0, 32'h134,
                1'b1, 5'd18, 0, 0, 0);

        @(posedge clk); #1;
        check("drain.mv", 32'(mem_valid), 32'd0);

        ex_valid   = 1'b1;
        ex_lsu_op  = 4'd3;
        ex_result  = 32'h0000_4000;
        ex_rw_en   = 1'b1;
        ex_rw_addr = 5'd3;
        @(posedge clk); #1;
        ex_valid   = 1'b0;
        ex_lsu_op  = 4'd0;
        dreq_ready = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        check("rstmid.in_resp", 32'(ex_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.ex_ready", 32'(ex_ready), 32'd1);
        check("rstmid.dreq", 32'(dreq_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drsp_valid = 1'b1;
        drsp_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        drsp_valid = 1'b0;
        check("rstmid.late_mv", 32'(mem_valid), 32'd0);
        check("rstmid.late_ready", 32'(ex_ready), 32'd1);
        check("rstmid.late_dreq", 32'(dreq_valid), 32'd0);
        @(posedge clk); #1;
        check("rstmid.after_mv", 32'(mem_valid), 32'd0);

        for (int n = 0; n < 80; n++) begin
            op   = int'($urandom_range(0, 15));
            addr = $urandom;
            r    = int'($urandom_range(0, 3));
            if (r == 0) addr[1:0] = 2'b00;
            if (r == 1) addr[0] = 1'b0;
            run_txn("rnd", op, addr, $urandom, $urandom, $urandom,
                    1'($urandom), 5'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)));
        end

        @(posedge clk); #1;
        check("end.mv", 32'(mem_valid), 32'd0);
        check("end.ex_ready", 32'(ex_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
